// File: rtl/demux_route_ctrl.sv
// demux_route_ctrl: routes the first len0 words of a transfer to destination 0 and the next len1 to destination 1
// through a single registered output stage that drives the demux data input and selector.
module demux_route_ctrl #(
    parameter int DWIDTH    = 32,
    parameter int CNT_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] cfg_len0,
    input  logic [CNT_WIDTH-1:0] cfg_len1,
    input  logic [DWIDTH-1:0]    s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [DWIDTH-1:0]    d_out,
    output logic                 sel_out,
    output logic                 d_valid0,
    output logic                 d_valid1,
    input  logic                 d_ready0,
    input  logic                 d_ready1,
    output logic                 busy,
    output logic                 done
);
    typedef enum logic [1:0] {IDLE, ROUTE0, ROUTE1, DRAIN} state_t;
    localparam logic [CNT_WIDTH-1:0] ONE = 1;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, len0_q, len0_d, len1_q, len1_d;
    logic [DWIDTH-1:0]    d_q, d_d;
    logic                 sel_q, sel_d, ov_q, ov_d, arm_q, arm_d;
    logic                 out_ready, acc, last;

    assign out_ready = sel_q ? d_ready1 : d_ready0;
    assign s_ready   = (state_q == ROUTE0 || state_q == ROUTE1) && (!ov_q || out_ready);
    assign acc       = s_valid && s_ready;
    assign last      = cnt_q == ((state_q == ROUTE0 ? len0_q : len1_q) - ONE);
    assign d_out     = d_q;
    assign sel_out   = sel_q;
    assign d_valid0  = ov_q && !sel_q;
    assign d_valid1  = ov_q && sel_q;
    assign busy      = state_q != IDLE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len0_d  = len0_q;
        len1_d  = len1_q;
        d_d     = d_q;
        sel_d   = sel_q;
        ov_d    = ov_q && !out_ready;
        arm_d   = 1'b0;
        done    = 1'b0;
        if (acc) begin
            d_d   = s_data;
            sel_d = state_q == ROUTE1;
            ov_d  = 1'b1;
            cnt_d = last ? '0 : cnt_q + ONE;
        end
        case (state_q)
            IDLE: if (start) begin
                len0_d  = cfg_len0;
                len1_d  = cfg_len1;
                cnt_d   = '0;
                state_d = cfg_len0 != '0 ? ROUTE0 : cfg_len1 != '0 ? ROUTE1 : DRAIN;
            end
            ROUTE0: if (acc && last) state_d = len1_q != '0 ? ROUTE1 : DRAIN;
            ROUTE1: if (acc && last) state_d = DRAIN;
            DRAIN: begin
                // arm_q keeps DRAIN at least one full cycle, so done trails the last handshake by one cycle
                arm_d = 1'b1;
                if (arm_q && !ov_q) begin
                    done    = 1'b1;
                    arm_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len0_q  <= '0;
            len1_q  <= '0;
            d_q     <= '0;
            sel_q   <= 1'b0;
            ov_q    <= 1'b0;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len0_q  <= len0_d;
            len1_q  <= len1_d;
            d_q     <= d_d;
            sel_q   <= sel_d;
            ov_q    <= ov_d;
            arm_q   <= arm_d;
        end
    end
endmodule

// File: tb/tb_demux_route_ctrl.sv
// tb_demux_route_ctrl: randomized scoreboard bench; expected words are queued from the transfer lengths
// and a monitor pops them on every output handshake.
module tb_demux_route_ctrl;
    localparam int DW = 32;
    localparam int CW = 10;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [CW-1:0] cfg_len0 = '0, cfg_len1 = '0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0, d_ready0 = 1'b0, d_ready1 = 1'b0;
    logic          s_ready, sel_out, d_valid0, d_valid1, busy, done;
    logic [DW-1:0] d_out;

    int            checks = 0, errors = 0;
    logic [DW:0]   exp_q[$];

    demux_route_ctrl #(.DWIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_len0(cfg_len0), .cfg_len1(cfg_len1),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .d_out(d_out), .sel_out(sel_out),
        .d_valid0(d_valid0), .d_valid1(d_valid1), .d_ready0(d_ready0), .d_ready1(d_ready1),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        logic [DW:0] e;
        if (rst_n) begin
            chk("one_valid", 64'(d_valid0 && d_valid1), 0);
            if ((d_valid0 && d_ready0) || (d_valid1 && d_ready1)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h, expected none", {sel_out, d_out});
                end else begin
                    e = exp_q.pop_front();
                    chk("word_tag_data", {sel_out, d_out}, e);
                    chk("valid_matches_tag", d_valid1, e[DW]);
                end
            end
        end
    end

    task automatic run_xfer(input int l0, input int l1, input int pv, input bit rmode, input int stall_at,
                            input int bstart_at, input int rst_at, input bit seq, input bit contig);
        logic [DW-1:0] stim[$];
        logic [DW-1:0] d;
        int n = l0 + l1;
        int i = 0, k = 0, dones = 0, hs_k = -1, done_k = -1;
        int vfirst = -1, vlast = -1, vcnt = 0, stall_left = 0;
        int budget = 30 * n + 40;
        bit fin = 0;
        for (int j = 0; j < n; j++) begin
            d = seq ? DW'(16 + j) : $urandom;
            stim.push_back(d);
            exp_q.push_back({1'(j >= l0), d});
        end
        @(posedge clk); #1;
        start = 1'b1;
        cfg_len0 = CW'(l0);
        cfg_len1 = CW'(l1);
        @(posedge clk); #1;
        start = 1'b0;
        while (!fin && k < budget) begin
            k++;
            start = (bstart_at == k);
            if (bstart_at == k) begin
                cfg_len0 = CW'($urandom);
                cfg_len1 = CW'($urandom);
            end
            s_valid = (i < n) && ($urandom_range(0, 99) < pv);
            if (i < n) s_data = stim[i];
            if (stall_left > 0) begin
                d_ready0 = 1'b0;
                d_ready1 = 1'b1;
            end else if (rmode) begin
                d_ready0 = $urandom_range(0, 3) != 0;
                d_ready1 = $urandom_range(0, 3) != 0;
            end else begin
                d_ready0 = 1'b1;
                d_ready1 = 1'b1;
            end
            @(negedge clk);
            if (stall_left > 0) begin
                chk("stall_sel", sel_out, 0);
                chk("stall_s_ready", s_ready, 0);
                chk("stall_hold", d_valid0, 1);
                stall_left--;
            end
            if (d_valid0 || d_valid1) begin
                vcnt++;
                if (vfirst < 0) vfirst = k;
                vlast = k;
            end
            if ((d_valid0 && d_ready0) || (d_valid1 && d_ready1)) hs_k = k;
            if (s_valid && s_ready) begin
                i++;
                if (i == stall_at) stall_left = 3;
            end
            if (done) begin
                dones++;
                done_k = k;
                fin = 1;
                chk("busy_at_done", busy, 1);
            end
            if (rst_at > 0 && i == rst_at) begin
                @(posedge clk); #1;
                rst_n = 1'b0;
                s_valid = 1'b0;
                #1;
                chk("reset_mid_outputs", {d_out, sel_out, d_valid0, d_valid1, s_ready, busy, done}, 0);
                exp_q.delete();
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        s_valid = 1'b0;
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles (len0=%0d len1=%0d)", budget, l0, l1);
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (j == 0) chk("busy_after_done", busy, 0);
            if (done) dones++;
        end
        chk("done_count", dones, 1);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("done_timing", done_k, n == 0 ? 2 : hs_k + 1);
        if (n == 0) chk("empty_no_valid", vcnt, 0);
        if (contig) begin
            chk("valid_cycles", vcnt, 5);
            chk("valid_contiguous", vlast - vfirst + 1, 5);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #1;
        chk("reset_outputs", {d_out, sel_out, d_valid0, d_valid1, s_ready, busy, done}, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_xfer(3, 2, 100, 0, 0, 0, 0, 1, 1);
        run_xfer(2, 2, 100, 0, 2, 0, 0, 0, 0);
        run_xfer(0, 4, 100, 0, 0, 0, 0, 0, 0);
        run_xfer(4, 0, 100, 0, 0, 0, 0, 0, 0);
        run_xfer(0, 0, 100, 0, 0, 0, 0, 0, 0);
        run_xfer(5, 6, 100, 0, 0, 3, 0, 0, 0);
        run_xfer(3, 2, 100, 0, 0, 0, 2, 0, 0);
        run_xfer(1, 1, 100, 0, 0, 0, 0, 0, 0);
        run_xfer(1023, 1023, 100, 0, 0, 0, 0, 0, 0);
        for (int t = 0; t < 20; t++)
            run_xfer($urandom_range(0, 8), $urandom_range(0, 8), 60, 1, 0, 0, 0, 0, 0);
        for (int t = 0; t < 4; t++)
            run_xfer($urandom_range(0, 1023), $urandom_range(0, 1023), 70, 1, 0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
